// File: rtl/wb_port_arbiter.sv
// Two-requester arbiter for the register file write-back port.
// req0 (pipeline WB) has fixed priority. req1 (multi-cycle unit) is forced a
// grant once it has waited STARVE_LIMIT cycles. The write-back outputs are registered.
module wb_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [3:0]       req0_dest,
  input  logic [31:0]      req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [3:0]       req1_dest,
  input  logic [31:0]      req1_data,
  output logic             req1_ready,
  output logic             wb_en,
  output logic [3:0]       wb_dest,
  output logic [31:0]      wb_data,
  output logic             req0_stall,
  output logic [CNT_W-1:0] starve_cnt
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic             force1;
  logic [CNT_W-1:0] cnt_nxt;
  logic             wb_en_nxt;
  logic [3:0]       wb_dest_nxt;
  logic [31:0]      wb_data_nxt;

  // Grant decode. starve_cnt is held at 0 during reset, so force1 and the stall are low then too.
  always_comb begin
    force1     = req1_valid & (starve_cnt == LIMIT);
    req1_ready = rst & req1_valid & (force1 | ~req0_valid);
    req0_ready = rst & req0_valid & ~force1;
    req0_stall = req0_valid & force1;
  end

  // Next starvation count and next write-back payload.
  always_comb begin
    cnt_nxt     = '0;
    wb_en_nxt   = req0_ready | req1_ready;
    wb_dest_nxt = wb_dest;
    wb_data_nxt = wb_data;
    if (req1_valid && !req1_ready) begin
      cnt_nxt = (starve_cnt == LIMIT) ? starve_cnt : starve_cnt + CNT_W'(1);
    end
    if (req0_ready) begin
      wb_dest_nxt = req0_dest;
      wb_data_nxt = req0_data;
    end else if (req1_ready) begin
      wb_dest_nxt = req1_dest;
      wb_data_nxt = req1_data;
    end
  end

  // Counter and registered write-back stage. An asynchronous reset drops any transfer in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
      wb_en      <= 1'b0;
      wb_dest    <= '0;
      wb_data    <= '0;
    end else begin
      starve_cnt <= cnt_nxt;
      wb_en      <= wb_en_nxt;
      wb_dest    <= wb_dest_nxt;
      wb_data    <= wb_data_nxt;
    end
  end

endmodule
